// File: rtl/ringosc_freq_meter_if.sv
// ringosc_freq_meter_if: osc/enable inputs and measurement outputs of ringosc_freq_meter.
// res_min/res_max exist only when RINGOSC_MINMAX_EN is defined.
interface ringosc_freq_meter_if #(
    parameter int CNT_W = 24
);
    logic             osc_in;
    logic             enable;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             overflow;
    logic [7:0]       led;
`ifdef RINGOSC_MINMAX_EN
    logic [CNT_W-1:0] res_min;
    logic [CNT_W-1:0] res_max;
    modport master (input osc_in, enable, output result, result_valid, overflow, led, res_min, res_max);
    modport slave (output osc_in, enable, input result, result_valid, overflow, led, res_min, res_max);
`else
    modport master (input osc_in, enable, output result, result_valid, overflow, led);
    modport slave (output osc_in, enable, input result, result_valid, overflow, led);
`endif
endinterface

// File: rtl/ringosc_freq_meter.sv
// ringosc_freq_meter: counts synchronised ring-oscillator rising edges over back-to-back gate windows.
// Optional RINGOSC_MINMAX_EN adds running min/max of published results.
module ringosc_freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int LED_LSB     = 12
) (
    input logic                  clk,
    input logic                  rst_n,
    ringosc_freq_meter_if.master bus
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam int AW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;

    state_t           state, state_d;
    logic [SYNC_STAGES-1:0] sync;
    logic             prev;
    logic [AW-1:0]    arm_ctr;
    logic [GW-1:0]    gate_ctr;
    logic [CNT_W-1:0] edge_ctr, cnt_d, result;
    logic             ovf, result_valid, overflow;
    logic [7:0]       led;
    logic             rise, at_max, start, arm_go, gating, term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.osc_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        rise    = sync[SYNC_STAGES-1] & ~prev;
        at_max  = &edge_ctr;
        cnt_d   = at_max ? edge_ctr : edge_ctr + CNT_W'(rise);
        start   = state == IDLE && bus.enable;
        arm_go  = state == ARM && bus.enable && arm_ctr == '0;
        gating  = state == GATE && bus.enable;
        term    = gating && gate_ctr == '0;
        state_d = !bus.enable ? IDLE : start ? ARM : arm_go ? GATE : state;
    end

    // Terminal cycle reloads the window and folds in this cycle's edge, so windows abut exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_ctr      <= '0;
            gate_ctr     <= '0;
            edge_ctr     <= '0;
            ovf          <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            led          <= '0;
        end else begin
            result_valid <= term;
            if (start) arm_ctr <= AW'(SYNC_STAGES);
            else if (state == ARM && arm_ctr != '0) arm_ctr <= arm_ctr - 1'b1;
            if (arm_go || term) begin
                gate_ctr <= GW'(GATE_CYCLES - 1);
                edge_ctr <= '0;
                ovf      <= 1'b0;
            end else if (gating) begin
                gate_ctr <= gate_ctr - 1'b1;
                edge_ctr <= cnt_d;
                ovf      <= ovf | (rise & at_max);
            end
            if (term) begin
                result   <= cnt_d;
                overflow <= ovf | (rise & at_max);
                led      <= 8'(cnt_d >> LED_LSB);
            end
        end
    end

    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.overflow     = overflow;
    assign bus.led          = led;

`ifdef RINGOSC_MINMAX_EN
    logic [CNT_W-1:0] res_min, res_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_min <= '1;
            res_max <= '0;
        end else if (start) begin
            res_min <= '1;
            res_max <= '0;
        end else if (term) begin
            res_min <= cnt_d < res_min ? cnt_d : res_min;
            res_max <= cnt_d > res_max ? cnt_d : res_max;
        end
    end

    assign bus.res_min = res_min;
    assign bus.res_max = res_max;
`endif
endmodule
